// File: rtl/lsu_bus_unit.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_unit
// Purpose  : Load/store unit behind the Memory stage. Turns an M-stage access
//            into a req/ack transaction on a word-wide bus. It places store
//            bytes on the correct lanes, extends load data, and stalls the
//            pipeline while a transaction is outstanding.
// Ports    : clk, reset (async, active-low)
//            MemWriteM/MemReadM/funct3M/Mem_WrAddr/Mem_WrData : M-stage access
//            ReadData   : extended load data, valid in the DONE cycle
//            StallM     : hold F/D/E/M while the access is in flight
//            misaligned : pulse for a misaligned address or illegal funct3
//            bus_err    : pulse after an ack timeout
//            bus_req/we/addr/be/wdata (registered), bus_rdata, bus_ack : bus
// Revision : 1.0  initial release
// ============================================================================
module lsu_bus_unit #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        StallM,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_f3;
  logic [1:0]    r_lane;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_access;
  logic          w_f3_ok;
  logic          w_align_ok;
  logic          w_legal;
  logic          w_start;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;

  // ---------------------------------------------------------------------------
  // Access decode and legality
  // ---------------------------------------------------------------------------
  assign w_access = MemWriteM | MemReadM;

  always_comb begin
    w_f3_ok = 1'b0;
    if (MemWriteM) begin
      // A simultaneous read strobe is ignored: the access is a store.
      w_f3_ok = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
    end else begin
      w_f3_ok = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010) ||
                (funct3M == 3'b100) || (funct3M == 3'b101);
    end
  end

  always_comb begin
    w_align_ok = 1'b1;
    case (funct3M[1:0])
      2'b01:   w_align_ok = ~Mem_WrAddr[0];
      2'b10:   w_align_ok = (Mem_WrAddr[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  assign w_legal = w_f3_ok & w_align_ok;
  assign w_start = (r_state == S_IDLE) & w_access & w_legal;

  // Size-based lane mask and lane-replicated write data. Loads reuse the
  // mask; their write data is don't-care on the bus since bus_we is 0.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = Mem_WrData;
    case (funct3M[1:0])
      2'b00: begin
        w_be    = 4'b0001 << Mem_WrAddr[1:0];
        w_wdata = {4{Mem_WrData[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << Mem_WrAddr[1:0];
        w_wdata = {2{Mem_WrData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = Mem_WrData;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extension from the held read word
  // ---------------------------------------------------------------------------
  assign w_byte = r_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = r_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = r_rdata;
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = r_rdata;
    endcase
  end

  assign ReadData   = (r_state == S_DONE) ? w_ext : 32'd0;
  assign StallM     = w_start | (r_state == S_WAIT);
  // Illegal accesses retire in the same IDLE cycle, so the flag is flagged
  // alongside them rather than a cycle later.
  assign misaligned = reset & (r_state == S_IDLE) & w_access & ~w_legal;
  assign bus_err    = r_err;

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered bus outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_f3      <= 3'd0;
      r_lane    <= 2'd0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // bus_ack is ignored here: no request is outstanding.
          if (w_start) begin
            r_f3      <= funct3M;
            r_lane    <= Mem_WrAddr[1:0];
            r_cnt     <= '0;
            bus_req   <= 1'b1;
            bus_we    <= MemWriteM;
            bus_addr  <= {Mem_WrAddr[31:2], 2'b00};
            bus_be    <= w_be;
            bus_wdata <= w_wdata;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An ack on the expiry cycle takes priority over the timeout.
          if (bus_ack) begin
            r_rdata <= bus_rdata;
            bus_req <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == C_LAST) begin
            r_rdata <= 32'd0;
            bus_req <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // M-stage inputs are still the retiring access; do not resample.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu_bus_unit.md
Name: lsu_bus_unit

Overview:
- Load/store unit directly downstream of the pipelined datapath's Memory stage.
- Consumes the memory-stage access: address, store data, write/read strobes and funct3.
- Runs a req/ack transaction on a word-wide data bus, aligns and byte-enables stores, and sign/zero-extends loads into ReadData for the M/W pipeline register.
- Asserts StallM while a bus transaction is outstanding, replacing the tied-off stall.

Parameters:
- TIMEOUT, 16, bus cycles to wait for bus_ack before abandoning the access (must be ≥ 2).
- CW, 5, width of the timeout counter (2^CW > TIMEOUT).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemWriteM  input  1  store in Memory stage.
- MemReadM  input  1  load in Memory stage.
- funct3M  input  3  access size/sign (RV32I encoding).
- Mem_WrAddr  input  32  byte address (ALUResultM).
- Mem_WrData  input  32  store data, right-justified.
- ReadData  output  32  extended load data; valid in the DONE cycle.
- StallM  output  1  hold F/D/E/M pipeline registers.
- misaligned  output  1  one-cycle pulse: misaligned address or illegal funct3.
- bus_err  output  1  one-cycle pulse: timeout expired.
- bus_req  output  1  registered request, held until ack.
- bus_we  output  1  registered; 1 = write.
- bus_addr  output  32  registered word address, {addr[31:2],2'b00}.
- bus_be  output  4  registered byte enables.
- bus_wdata  output  32  registered lane-replicated store data.
- bus_rdata  input  32  read data, sampled on ack.
- bus_ack  input  1  one-cycle completion strobe.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - bus_req, bus_we, bus_addr, bus_be, bus_wdata go to 0; the rdata hold register goes to 0.
  - misaligned and bus_err go to 0. Counter goes to 0.
  - Reset mid-transaction drops bus_req immediately; a late ack after reset is ignored.
- An access is MemWriteM|MemReadM. If both are 1, the access is treated as a store.
- Legality:
  - funct3 ∈ {000, 001, 010} for stores.
  - funct3 ∈ {000, 001, 010, 100, 101} for loads.
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Otherwise the access is illegal.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: be = 0011 << addr[1:0]; wdata = {2{data[15:0]}}.
  - SW: be = 1111; wdata = data.
  - Loads: be = the same size-based mask; bus_we = 0.
- Load extension from the held rdata, latched addr[1:0] and funct3:
  - LB / LBU: byte lane addr[1:0], sign- / zero-extended.
  - LH / LHU: lane addr[1], sign- / zero-extended.
  - LW: full word.
- FSM IDLE:
  - No access: StallM=0; ReadData=0.
  - Legal access: StallM=1 (combinational). Latch addr/be/wdata/we/funct3, set bus_req, clear the counter, go to WAIT.
  - Illegal access: no bus request. misaligned=1 for exactly that cycle; StallM=0, so the instruction retires with ReadData=0 and the store is suppressed. Stay in IDLE.
  - bus_ack while in IDLE is ignored.
- FSM WAIT:
  - StallM=1; bus_* are held stable.
  - bus_ack=1: capture bus_rdata, clear bus_req, go to DONE.
  - No ack: increment the counter. When the counter reaches TIMEOUT-1 without ack: clear bus_req, zero the rdata hold register, pulse bus_err in the next cycle, go to DONE.
  - An ack in the same cycle as expiry wins: normal completion, no bus_err.
- FSM DONE:
  - Exactly one cycle, then IDLE.
  - StallM=0; ReadData valid; the pipeline advances at the end of this cycle.
  - The M-stage inputs are not re-sampled in DONE, so there is no duplicate access. The next access is evaluated in the following IDLE cycle.
- Latency:
  - Ack in the first WAIT cycle gives 3 cycles per access: IDLE-detect, WAIT, DONE.
  - Back-to-back accesses: each takes 2 + (wait cycles).
- StallM is the only stall source from this block. The hazard unit ORs it into StallF/D/E/M.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF, ack in first WAIT cycle → bus_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; StallM high for 2 cycles; DONE 1 cycle later.
2. SB addr 0x103, data 0x000000A5 → be=1000, wdata=0xA5A5A5A5, bus_addr=0x100.
3. LB addr 0x102, rdata 0x12F03456 → ReadData=0xFFFFFFF0. LBU at the same address → 0x000000F0. LH addr 0x102 → 0x000012F0.
4. LW addr 0x101 → misaligned pulse 1 cycle, bus_req never asserted, StallM=0. SH with funct3=011 → misaligned.
5. LW with no ack, TIMEOUT=16 → bus_req high 16 cycles then low; bus_err pulse; ReadData=0 in DONE; ack on the expiry cycle → normal completion, no bus_err.
6. Assert reset during WAIT → bus_req=0 immediately; after release, a stray bus_ack is ignored; a new LW completes correctly.
